// File: rtl/pwm_cfg_sequencer.sv
// Command-driven PWM config sequencer: decodes 32-bit words into enable, ramped duty and period-aligned frequency (optional soft start: PWM_CFG_SEQ_SOFTSTART_EN).
// Latency: enable/duty/freq_pending update one cycle after accept; frequency commits the cycle after the clearing period_end.
// Backpressure: cmd_ready drops only while a frequency update is pending; all other commands are accepted in any state.
`timescale 1ns/1ps
module pwm_cfg_sequencer #(
    parameter int DUTY_W = 24,
    parameter int FREQ_W = 32
) (
    input  logic              pwm_clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    input  logic [31:0]       cmd_data,
    output logic              cmd_ready,
    input  logic              period_end,
    output logic              pwm_enable,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic [FREQ_W-1:0] frequency,
    output logic              ramp_busy,
    output logic              freq_pending
);

    typedef enum logic {S_IDLE = 1'b0, S_RAMP = 1'b1} state_t;

    state_t state_q, state_nxt;

    logic [DUTY_W-1:0] target_q, target_nxt, duty_nxt, stepped, step_d;
    logic [15:0]       step_q, step_nxt;
    logic [13:0]       interval_q, interval_nxt, cnt_q, cnt_nxt, cnt_inc, interval_eff;
    logic [FREQ_W-1:0] shadow_q, shadow_nxt, freq_nxt;
    logic              en_nxt, pend_nxt, busy_nxt;

    logic [DUTY_W:0]   duty_x, target_x, step_x, up_sum, dn_lim;
    logic              accept, ramp_active, step_due, enable_rise;
    logic [1:0]        hdr;
    logic [29:0]       payload;

    assign cmd_ready = ~freq_pending;
    assign accept    = cmd_valid & cmd_ready;
    assign hdr       = cmd_data[31:30];
    assign payload   = cmd_data[29:0];

`ifdef PWM_CFG_SEQ_SOFTSTART_EN
    assign enable_rise = accept && (hdr == 2'b00) && payload[0] && !pwm_enable;
`else
    assign enable_rise = 1'b0;
`endif

    // Step arithmetic is one bit wider than duty so closeness tests cannot wrap.
    always_comb begin
        step_d       = DUTY_W'(step_q);
        step_x       = {1'b0, step_d};
        duty_x       = {1'b0, duty_cycle};
        target_x     = {1'b0, target_q};
        up_sum       = duty_x + step_x;
        dn_lim       = target_x + step_x;
        stepped      = target_q;
        if (target_x > duty_x) begin
            if (up_sum < target_x) stepped = up_sum[DUTY_W-1:0];
        end else begin
            if (duty_x > dn_lim) stepped = duty_cycle - step_d;
        end
        interval_eff = (interval_q == 14'd0) ? 14'd1 : interval_q;
        cnt_inc      = cnt_q + 14'd1;
        step_due     = ramp_active && period_end && (cnt_inc >= interval_eff);
    end

    always_comb begin
        en_nxt       = pwm_enable;
        target_nxt   = target_q;
        step_nxt     = step_q;
        interval_nxt = interval_q;
        shadow_nxt   = shadow_q;
        pend_nxt     = freq_pending;
        freq_nxt     = frequency;

        // A disabled PWM never wraps, so commit without waiting for a boundary.
        if (freq_pending && (period_end || !pwm_enable)) begin
            freq_nxt = shadow_q;
            pend_nxt = 1'b0;
        end

        if (accept) begin
            case (hdr)
                2'b00: en_nxt = payload[0];
                2'b01: target_nxt = payload[DUTY_W-1:0];
                2'b10: begin
                    shadow_nxt = FREQ_W'(payload);
                    pend_nxt   = 1'b1;
                end
                2'b11: begin
                    step_nxt     = payload[15:0];
                    interval_nxt = payload[29:16];
                end
                default: en_nxt = pwm_enable;
            endcase
        end

        if (enable_rise)          duty_nxt = '0;
        else if (step_q == 16'd0) duty_nxt = target_nxt;
        else if (step_due)        duty_nxt = stepped;
        else                      duty_nxt = duty_cycle;

        if (!ramp_active)     cnt_nxt = '0;
        else if (step_due)    cnt_nxt = '0;
        else if (period_end)  cnt_nxt = cnt_inc;
        else                  cnt_nxt = cnt_q;

        busy_nxt = (duty_nxt != target_nxt);
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: if ((duty_nxt != target_nxt) && (step_nxt != 16'd0)) state_nxt = S_RAMP;
            S_RAMP: if ((duty_nxt == target_nxt) || (step_nxt == 16'd0)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ramp_active = (state_q == S_RAMP);
    end

    always_ff @(posedge pwm_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pwm_enable   <= 1'b0;
            duty_cycle   <= '0;
            frequency    <= '0;
            ramp_busy    <= 1'b0;
            freq_pending <= 1'b0;
            target_q     <= '0;
            step_q       <= '0;
            interval_q   <= 14'd1;
            cnt_q        <= '0;
            shadow_q     <= '0;
        end else begin
            state_q      <= state_nxt;
            pwm_enable   <= en_nxt;
            duty_cycle   <= duty_nxt;
            frequency    <= freq_nxt;
            ramp_busy    <= busy_nxt;
            freq_pending <= pend_nxt;
            target_q     <= target_nxt;
            step_q       <= step_nxt;
            interval_q   <= interval_nxt;
            cnt_q        <= cnt_nxt;
            shadow_q     <= shadow_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Bench for pwm_cfg_sequencer: directed command sequences checked against a behavioural model every cycle.
`timescale 1ns/1ps
module tb_pwm_cfg_sequencer;

    logic        pwm_clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_data = 32'h0;
    logic        period_end = 1'b0;
    logic        cmd_ready, pwm_enable, ramp_busy, freq_pending;
    logic [23:0] duty_cycle;
    logic [31:0] frequency;

    int checks = 0;
    int errors = 0;

    pwm_cfg_sequencer #(.DUTY_W(24), .FREQ_W(32)) dut (
        .pwm_clk(pwm_clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .period_end(period_end), .pwm_enable(pwm_enable),
        .duty_cycle(duty_cycle), .frequency(frequency), .ramp_busy(ramp_busy),
        .freq_pending(freq_pending)
    );

    always #5 pwm_clk = ~pwm_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Model state: what the outputs and hidden registers must hold.
    bit          m_en = 0, m_pend = 0;
    int unsigned m_duty = 0, m_target = 0, m_step = 0, m_interval = 1, m_cnt = 0;
    int unsigned m_shadow = 0, m_freq = 0;
    bit          acc, ramping, forced, n_en, n_pend;
    int unsigned p, n_duty, n_target, n_step, n_interval, n_cnt, n_shadow;

    function automatic int unsigned toward(input int unsigned d, input int unsigned t, input int unsigned s);
        if (t > d) return (t - d <= s) ? t : d + s;
        return (d - t <= s) ? t : d - s;
    endfunction

    always @(posedge pwm_clk or negedge reset_n) begin
        if (!reset_n) begin
            m_en = 0; m_pend = 0; m_duty = 0; m_target = 0; m_step = 0;
            m_interval = 1; m_cnt = 0; m_shadow = 0; m_freq = 0;
        end else begin
            acc = cmd_valid && !m_pend;
            p = cmd_data[29:0];
            ramping = (m_duty != m_target) && (m_step != 0);
            n_en = m_en; n_pend = m_pend; n_duty = m_duty; n_target = m_target;
            n_step = m_step; n_interval = m_interval; n_cnt = m_cnt; n_shadow = m_shadow;
            forced = 0;
            if (!ramping) n_cnt = 0;
            else if (period_end) begin
                n_cnt = m_cnt + 1;
                if (n_cnt >= ((m_interval == 0) ? 1 : m_interval)) begin
                    n_cnt = 0;
                    n_duty = toward(m_duty, m_target, m_step);
                end
            end
            if (m_pend && (period_end || !m_en)) begin
                m_freq = m_shadow;
                n_pend = 0;
            end
            if (acc) begin
                case (cmd_data[31:30])
                    2'b00: begin
                        n_en = (p & 1) != 0;
`ifdef PWM_CFG_SEQ_SOFTSTART_EN
                        if (n_en && !m_en) forced = 1;
`endif
                    end
                    2'b01: n_target = p & 32'h00FF_FFFF;
                    2'b10: begin n_shadow = p; n_pend = 1; end
                    default: begin n_step = p & 32'hFFFF; n_interval = (p >> 16) & 32'h3FFF; end
                endcase
            end
            if (forced) n_duty = 0;
            else if (m_step == 0) n_duty = n_target;
            m_en = n_en; m_pend = n_pend; m_duty = n_duty; m_target = n_target;
            m_step = n_step; m_interval = n_interval; m_cnt = n_cnt; m_shadow = n_shadow;
        end
    end

    always @(negedge pwm_clk) begin
        chk("cyc_enable", 32'(pwm_enable), 32'(m_en));
        chk("cyc_duty", 32'(duty_cycle), m_duty);
        chk("cyc_freq", frequency, m_freq);
        chk("cyc_ready", 32'(cmd_ready), 32'(!m_pend));
        chk("cyc_busy", 32'(ramp_busy), 32'(m_duty != m_target));
        chk("cyc_pend", 32'(freq_pending), 32'(m_pend));
    end

    task automatic idle(input int n);
        repeat (n) @(posedge pwm_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input bit pe = 1'b0);
        cmd_valid = 1'b1; cmd_data = w; period_end = pe;
        @(posedge pwm_clk);
        #1;
        cmd_valid = 1'b0; period_end = 1'b0;
    endtask

    task automatic pulse();
        period_end = 1'b1;
        @(posedge pwm_clk);
        #1;
        period_end = 1'b0;
        idle(2);
    endtask

    logic [23:0] ramp_exp [5] = '{24'h001000, 24'h002000, 24'h003000, 24'h004000, 24'h004800};

    initial begin
        #2 reset_n = 1'b0;
        repeat (2) @(posedge pwm_clk);
        #1 reset_n = 1'b1;
        idle(1);
        chk("rst_enable", 32'(pwm_enable), 32'h0);
        chk("rst_duty", 32'(duty_cycle), 32'h0);
        chk("rst_freq", frequency, 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        chk("rst_busy", 32'(ramp_busy), 32'h0);
        chk("rst_pend", 32'(freq_pending), 32'h0);

        send(32'h4000_8000);
        chk("step0_duty", 32'(duty_cycle), 32'h8000);
        chk("step0_busy", 32'(ramp_busy), 32'h0);
        send(32'h4000_0000);
        chk("step0_zero", 32'(duty_cycle), 32'h0);

        send(32'hC002_1000);
        send(32'h4000_4800);
        chk("ramp_busy_on", 32'(ramp_busy), 32'h1);
        for (int i = 0; i < 5; i++) begin
            pulse();
            chk("ramp_hold", 32'(duty_cycle), (i == 0) ? 32'h0 : 32'(ramp_exp[i-1]));
            pulse();
            chk("ramp_step", 32'(duty_cycle), 32'(ramp_exp[i]));
        end
        chk("ramp_busy_off", 32'(ramp_busy), 32'h0);

        send(32'h0000_0001);
        send(32'h8000_1234);
        chk("fp_pend", 32'(freq_pending), 32'h1);
        chk("fp_ready", 32'(cmd_ready), 32'h0);
        idle(4);
        chk("fp_hold", frequency, 32'h0);
        pulse();
        chk("fp_commit", frequency, 32'h0000_1234);
        chk("fp_ready_back", 32'(cmd_ready), 32'h1);

        send(32'h0000_0000);
        send(32'hBFFF_FFFF);
        chk("fd_pend", 32'(freq_pending), 32'h1);
        chk("fd_hold", frequency, 32'h0000_1234);
        idle(1);
        chk("fd_commit", frequency, 32'h3FFF_FFFF);

        send(32'hC001_0000);
        send(32'h4000_3000);
        send(32'hC001_1000);
        send(32'h4000_8000);
        chk("rt_start", 32'(duty_cycle), 32'h3000);
        send(32'h4000_1000);
        pulse();
        chk("rt_step1", 32'(duty_cycle), 32'h2000);
        pulse();
        chk("rt_step2", 32'(duty_cycle), 32'h1000);
        chk("rt_idle", 32'(ramp_busy), 32'h0);

        send(32'h4000_3000);
        send(32'h4000_0000, 1'b1);
        chk("same_cyc_old_tgt", 32'(duty_cycle), 32'h2000);
        pulse();
        pulse();
        chk("same_cyc_down", 32'(duty_cycle), 32'h0);

        send(32'hC000_1000);
        send(32'h4000_1800);
        pulse();
        chk("iv0_step", 32'(duty_cycle), 32'h1000);
        pulse();
        chk("no_overshoot", 32'(duty_cycle), 32'h1800);

        send(32'h0000_0001);
        send(32'h8000_0055, 1'b1);
        chk("fs_pend", 32'(freq_pending), 32'h1);
        chk("fs_hold", frequency, 32'h3FFF_FFFF);
        pulse();
        chk("fs_commit", frequency, 32'h0000_0055);

        send(32'hC001_0100);
        send(32'h4000_8000);
        pulse();
        chk("mr_duty", 32'(duty_cycle), 32'h1900);
        send(32'h8000_0777);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_enable", 32'(pwm_enable), 32'h0);
        chk("mr_duty_rst", 32'(duty_cycle), 32'h0);
        chk("mr_freq", frequency, 32'h0);
        chk("mr_ready", 32'(cmd_ready), 32'h1);
        chk("mr_busy", 32'(ramp_busy), 32'h0);
        chk("mr_pend", 32'(freq_pending), 32'h0);
        @(posedge pwm_clk);
        #1 reset_n = 1'b1;
        idle(1);

        send(32'h4000_0300);
        send(32'hC001_0100);
        send(32'h0000_0001);
`ifdef PWM_CFG_SEQ_SOFTSTART_EN
        chk("ss_zero", 32'(duty_cycle), 32'h0);
        pulse();
        chk("ss_step", 32'(duty_cycle), 32'h0100);
`else
        chk("en_keeps_duty", 32'(duty_cycle), 32'h0300);
`endif
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
